// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the riscy ID stage: opcodes, branch funct3
// codes, immediate formats and the RUN/SHADOW state encoding.
// Width-dependent types (data_t, r_t, id_fwd_sel_t) are declared inside the
// modules because their sizes follow each instance's parameters.
package id_stage_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef enum logic {
        ST_RUN,
        ST_SHADOW
    } id_state_e;

    // Instruction format implied by the major opcode
    function automatic imm_fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_REG:                   return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: reassembles the I/S/B/U/J immediate from the
// instruction word and sign-extends it to XLEN. Unknown formats give 0.
module id_stage_imm_gen
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    // Pick the bit layout for the decoded format
    always_comb begin
        imm32 = '0;
        case (fmt_of(instr[6:0]))
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast sign-extends to 64 bits when XLEN is 64
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage_regfile.sv
// Integer register file: NREG x XLEN, two combinational read ports and one
// synchronous write port. x0 is never written and always reads zero.
// With BYPASS set, a read of the register being written returns the new data.
module id_stage_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [XLEN-1:0]         wd,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2
);

    logic [XLEN-1:0] mem [NREG];

    // Write port; writes to x0 are discarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 :
                 (BYPASS != 0 && we && wa == ra1) ? wd : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 :
                 (BYPASS != 0 && we && wa == ra2) ? wd : mem[ra2];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register read with forwarding, immediate
// generation, decode-time branch/jump resolution, load-use hazard detection
// and the ID/EX register behind a valid/ready handshake. After every
// redirect the next accepted fetch is a wrong-path shadow and is dropped.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int NFWD      = 3,
    parameter int BYPASS_WB = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [31:0]                  in_instr,
    input  logic                         wb_wren,
    input  logic [$clog2(NREG)-1:0]      wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic [NFWD*XLEN-1:0]         fwd_data,
    input  logic [$clog2(NFWD+1)-1:0]    fwd_sel_rs1,
    input  logic [$clog2(NFWD+1)-1:0]    fwd_sel_rs2,
    input  logic                         ex_load_pending,
    input  logic [$clog2(NREG)-1:0]      ex_rd,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_rs1,
    output logic [XLEN-1:0]              out_rs2,
    output logic [XLEN-1:0]              out_imm,
    output logic [31:0]                  out_instr,
    output logic                         pc_sel,
    output logic [XLEN-1:0]              pc_bj
);

    localparam int AW  = $clog2(NREG);
    localparam int FSW = $clog2(NFWD + 1);

    typedef logic [XLEN-1:0]        data_t;
    typedef logic signed [XLEN-1:0] sdata_t;
    typedef logic [AW-1:0]          r_t;
    typedef logic [FSW-1:0]         id_fwd_sel_t;

    // ---- p0: decode, operand fetch, branch resolution ----
    logic [6:0] opcode_p0;
    logic [2:0] f3_p0;
    imm_fmt_e   fmt_p0;
    r_t         rs1_a_p0, rs2_a_p0;
    data_t      rf_rd1_p0, rf_rd2_p0, rs1_p0, rs2_p0, imm_p0;
    sdata_t     rs1_s_p0, rs2_s_p0;
    data_t      pc_imm_p0, jalr_sum_p0, target_p0;
    logic       uses_rs2_p0, hazard_p0, accept_p0, taken_p0, redirect_p0;
    logic       is_branch_p0, is_jal_p0, is_jalr_p0;

    // ---- p1: ID/EX register ----
    id_state_e  state;
    logic       vld_p1;
    data_t      pc_p1, rs1_p1, rs2_p1, imm_p1;
    logic [31:0] instr_p1;

    assign opcode_p0 = in_instr[6:0];
    assign f3_p0     = in_instr[14:12];
    assign fmt_p0    = fmt_of(opcode_p0);
    assign rs1_a_p0  = r_t'(in_instr[19:15]);
    assign rs2_a_p0  = r_t'(in_instr[24:20]);

    id_stage_regfile #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .BYPASS (BYPASS_WB)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_wren),
        .wa    (wb_addr),
        .wd    (wb_data),
        .ra1   (rs1_a_p0),
        .ra2   (rs2_a_p0),
        .rd1   (rf_rd1_p0),
        .rd2   (rf_rd2_p0)
    );

    id_stage_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (in_instr),
        .imm   (imm_p0)
    );

    // Select 0 keeps the register-file value; k picks forwarding source k-1.
    // x0 reads zero no matter what the select says.
    function automatic data_t fwd_pick(input id_fwd_sel_t sel, input r_t addr,
                                       input data_t rf, input logic [NFWD*XLEN-1:0] src);
        data_t v;
        v = rf;
        for (int k = 0; k < NFWD; k++) begin
            if (sel == id_fwd_sel_t'(k + 1)) v = src[k*XLEN +: XLEN];
        end
        if (addr == '0) v = '0;
        return v;
    endfunction

    assign rs1_p0   = fwd_pick(fwd_sel_rs1, rs1_a_p0, rf_rd1_p0, fwd_data);
    assign rs2_p0   = fwd_pick(fwd_sel_rs2, rs2_a_p0, rf_rd2_p0, fwd_data);
    assign rs1_s_p0 = sdata_t'(rs1_p0);
    assign rs2_s_p0 = sdata_t'(rs2_p0);

    // The rs2 field is an immediate slice for I/U/J formats, so only R/S/B check it
    assign uses_rs2_p0 = (fmt_p0 == FMT_R) || (fmt_p0 == FMT_S) || (fmt_p0 == FMT_B);
    assign hazard_p0   = in_valid && ex_load_pending && (ex_rd != '0) &&
                         ((ex_rd == rs1_a_p0) || (uses_rs2_p0 && ex_rd == rs2_a_p0));
    assign in_ready    = !flush && !hazard_p0 && (!vld_p1 || out_ready);
    assign accept_p0   = in_valid && in_ready;

    // Branch condition on the forwarded operands
    always_comb begin
        taken_p0 = 1'b0;
        case (f3_p0)
            F3_BEQ:  taken_p0 = (rs1_p0 == rs2_p0);
            F3_BNE:  taken_p0 = (rs1_p0 != rs2_p0);
            F3_BLT:  taken_p0 = (rs1_s_p0 <  rs2_s_p0);
            F3_BGE:  taken_p0 = (rs1_s_p0 >= rs2_s_p0);
            F3_BLTU: taken_p0 = (rs1_p0 <  rs2_p0);
            F3_BGEU: taken_p0 = (rs1_p0 >= rs2_p0);
            default: taken_p0 = 1'b0;
        endcase
    end

    assign is_branch_p0 = (opcode_p0 == OP_BRANCH);
    assign is_jal_p0    = (opcode_p0 == OP_JAL);
    assign is_jalr_p0   = (opcode_p0 == OP_JALR);
    assign pc_imm_p0    = in_pc + imm_p0;
    assign jalr_sum_p0  = rs1_p0 + imm_p0;
    assign target_p0    = is_jalr_p0 ? {jalr_sum_p0[XLEN-1:1], 1'b0} : pc_imm_p0;

    // Only an instruction accepted in RUN may redirect; the shadow never does
    assign redirect_p0 = accept_p0 && (state == ST_RUN) &&
                         ((is_branch_p0 && taken_p0) || is_jal_p0 || is_jalr_p0);
    assign pc_sel      = rst_n && redirect_p0;
    assign pc_bj       = target_p0;

    // ID/EX register and RUN/SHADOW tracking; flush outranks acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            rs1_p1   <= '0;
            rs2_p1   <= '0;
            imm_p1   <= '0;
            instr_p1 <= '0;
        end else if (flush) begin
            state  <= ST_RUN;
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            if (state == ST_SHADOW) begin
                state  <= ST_RUN;
                vld_p1 <= 1'b0;
            end else begin
                vld_p1   <= 1'b1;
                pc_p1    <= in_pc;
                rs1_p1   <= rs1_p0;
                rs2_p1   <= rs2_p0;
                imm_p1   <= imm_p0;
                instr_p1 <= in_instr;
                if (redirect_p0) state <= ST_SHADOW;
            end
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_pc    = pc_p1;
    assign out_rs1   = rs1_p1;
    assign out_rs2   = rs2_p1;
    assign out_imm   = imm_p1;
    assign out_instr = instr_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register read/bypass, forwarding, x0,
// load-use hazard, branch/jump redirect with shadow drop, stall, flush, reset.
module tb_id_stage;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NFWD = 3;

    localparam logic [31:0] I_ADDI_6_5_3  = 32'h0032_8313;
    localparam logic [31:0] I_ADDI_8_7_0  = 32'h0003_8413;
    localparam logic [31:0] I_ADDI_1_0_0  = 32'h0000_0093;
    localparam logic [31:0] I_ADD_4_3_1   = 32'h0011_8233;
    localparam logic [31:0] I_ADD_4_1_3   = 32'h0030_8233;
    localparam logic [31:0] I_ADDI_4_1_3  = 32'h0030_8213;
    localparam logic [31:0] I_BEQ_1_2_16  = 32'h0020_8863;
    localparam logic [31:0] I_BLTU_1_2_16 = 32'h0020_E863;
    localparam logic [31:0] I_BLT_1_2_16  = 32'h0020_C863;
    localparam logic [31:0] I_JAL_0_8     = 32'h0080_006F;
    localparam logic [31:0] I_JALR_0_9_4  = 32'h0044_8067;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         in_pc;
    logic [31:0]             in_instr;
    logic                    wb_wren;
    logic [$clog2(NREG)-1:0] wb_addr;
    logic [XLEN-1:0]         wb_data;
    logic [NFWD*XLEN-1:0]    fwd_data;
    logic [1:0]              fwd_sel_rs1, fwd_sel_rs2;
    logic                    ex_load_pending;
    logic [$clog2(NREG)-1:0] ex_rd;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_pc, out_rs1, out_rs2, out_imm;
    logic [31:0]             out_instr;
    logic                    pc_sel;
    logic [XLEN-1:0]         pc_bj;

    int errs = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    id_stage #(
        .XLEN      (XLEN),
        .NREG      (NREG),
        .NFWD      (NFWD),
        .BYPASS_WB (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instr        (in_instr),
        .wb_wren         (wb_wren),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .fwd_data        (fwd_data),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .ex_load_pending (ex_load_pending),
        .ex_rd           (ex_rd),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_imm         (out_imm),
        .out_instr       (out_instr),
        .pc_sel          (pc_sel),
        .pc_bj           (pc_bj)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_wren = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        ex_load_pending = 1'b0; ex_rd = '0;
        fwd_data = '0; fwd_sel_rs1 = '0; fwd_sel_rs2 = '0;
        wb(1'b0, 5'd0, 32'h0);
        feed(1'b1, 32'h0, I_JAL_0_8);

        // Reset with a jump presented: no redirect, everything cleared
        @(negedge clk);
        check("pc_sel_in_reset", pc_sel, 0);
        tick(); tick();
        @(negedge clk);
        check("pc_sel_in_reset2", pc_sel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_rs1", out_rs1, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_instr", out_instr, 0);
        tick();

        // Write x5 then ADDI x6,x5,3
        rst_n = 1'b1;
        feed(1'b0, 32'h0, 32'h0);
        wb(1'b1, 5'd5, 32'h10);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        feed(1'b1, 32'h40, I_ADDI_6_5_3);
        @(negedge clk);
        check("addi_in_ready", in_ready, 1);
        check("addi_pc_sel", pc_sel, 0);
        tick();
        feed(1'b0, 32'h0, 32'h0);
        check("addi_out_valid", out_valid, 1);
        check("addi_out_rs1", out_rs1, 32'h10);
        check("addi_out_imm", out_imm, 32'h3);
        check("addi_out_pc", out_pc, 32'h40);
        tick();
        check("drain_out_valid", out_valid, 0);

        // Same-cycle write and read of x7 returns the new value
        wb(1'b1, 5'd7, 32'h77);
        feed(1'b1, 32'h44, I_ADDI_8_7_0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        feed(1'b0, 32'h0, 32'h0);
        check("bypass_rs1", out_rs1, 32'h77);
        tick();

        // x0 write ignored; x0 reads zero even with forwarding selected
        wb(1'b1, 5'd0, 32'hFF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        fwd_data[31:0] = 32'hAA;
        fwd_sel_rs1 = 2'd1;
        feed(1'b1, 32'h48, I_ADDI_1_0_0);
        tick();
        feed(1'b0, 32'h0, 32'h0);
        fwd_sel_rs1 = 2'd0;
        check("x0_rs1", out_rs1, 0);
        tick();

        // Load-use hazard on rs1 (R-type), then on rs2 (R-type)
        ex_load_pending = 1'b1; ex_rd = 5'd3;
        feed(1'b1, 32'h80, I_ADD_4_3_1);
        @(negedge clk);
        check("haz_rs1_in_ready", in_ready, 0);
        tick();
        check("haz_bubble_valid", out_valid, 0);
        feed(1'b1, 32'h80, I_ADD_4_1_3);
        @(negedge clk);
        check("haz_rs2_in_ready", in_ready, 0);
        tick();
        ex_load_pending = 1'b0;
        feed(1'b1, 32'h80, I_ADD_4_3_1);
        @(negedge clk);
        check("haz_release_ready", in_ready, 1);
        tick();
        check("haz_release_valid", out_valid, 1);
        check("haz_release_instr", out_instr, I_ADD_4_3_1);
        // I-type: the rs2 field holds imm bits and must not stall
        ex_load_pending = 1'b1; ex_rd = 5'd3;
        feed(1'b1, 32'h84, I_ADDI_4_1_3);
        @(negedge clk);
        check("itype_no_hazard", in_ready, 1);
        tick();
        check("itype_instr", out_instr, I_ADDI_4_1_3);
        ex_load_pending = 1'b0; ex_rd = '0;
        feed(1'b0, 32'h0, 32'h0);
        tick();

        // BEQ x1,x2,+16 with both operands from MEM; hazard first blocks it
        fwd_data[63:32] = 32'd7;
        fwd_sel_rs1 = 2'd2; fwd_sel_rs2 = 2'd2;
        ex_load_pending = 1'b1; ex_rd = 5'd2;
        feed(1'b1, 32'h100, I_BEQ_1_2_16);
        @(negedge clk);
        check("beq_haz_pc_sel", pc_sel, 0);
        check("beq_haz_ready", in_ready, 0);
        tick();
        ex_load_pending = 1'b0; ex_rd = '0;
        @(negedge clk);
        check("beq_pc_sel", pc_sel, 1);
        check("beq_pc_bj", pc_bj, 32'h110);
        tick();
        check("beq_out_imm", out_imm, 32'h10);
        check("beq_out_pc", out_pc, 32'h100);
        // Shadow fetch: a jump that must be dropped without redirect
        fwd_sel_rs1 = 2'd0; fwd_sel_rs2 = 2'd0;
        feed(1'b1, 32'h104, I_JAL_0_8);
        @(negedge clk);
        check("shadow_in_ready", in_ready, 1);
        check("shadow_pc_sel", pc_sel, 0);
        tick();
        feed(1'b0, 32'h0, 32'h0);
        check("shadow_dropped", out_valid, 0);
        tick();
        check("shadow_stays_empty", out_valid, 0);

        // Unsigned vs signed compare: -1 vs 1
        fwd_data[31:0]  = 32'hFFFF_FFFF;
        fwd_data[95:64] = 32'd1;
        fwd_sel_rs1 = 2'd1; fwd_sel_rs2 = 2'd3;
        feed(1'b1, 32'h200, I_BLTU_1_2_16);
        @(negedge clk);
        check("bltu_not_taken", pc_sel, 0);
        tick();
        feed(1'b1, 32'h204, I_BLT_1_2_16);
        @(negedge clk);
        check("blt_taken", pc_sel, 1);
        check("blt_pc_bj", pc_bj, 32'h214);
        tick();
        fwd_sel_rs1 = 2'd0; fwd_sel_rs2 = 2'd0;

        // Stall in SHADOW for three cycles
        out_ready = 1'b0;
        feed(1'b1, 32'h208, I_ADDI_6_5_3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_pc", out_pc, 32'h204);
            check("stall_out_instr", out_instr, I_BLT_1_2_16);
            tick();
        end
        // Flush while in SHADOW
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        check("flush_pc_sel", pc_sel, 0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", out_valid, 0);
        // Back in RUN: a jump redirects instead of being dropped
        feed(1'b1, 32'h300, I_JAL_0_8);
        @(negedge clk);
        check("post_flush_pc_sel", pc_sel, 1);
        check("post_flush_pc_bj", pc_bj, 32'h308);
        tick();

        // Reset while in SHADOW
        feed(1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        tick();
        check("rst_shadow_valid", out_valid, 0);
        check("rst_shadow_pc", out_pc, 0);
        check("rst_shadow_instr", out_instr, 0);
        rst_n = 1'b1;
        wb(1'b1, 5'd9, 32'h203);
        tick();
        wb(1'b0, 5'd0, 32'h0);

        // JALR x0,4(x9): target 0x207 with bit 0 cleared
        feed(1'b1, 32'h400, I_JALR_0_9_4);
        @(negedge clk);
        check("jalr_pc_sel", pc_sel, 1);
        check("jalr_pc_bj", pc_bj, 32'h206);
        tick();
        check("jalr_out_imm", out_imm, 32'h4);
        check("jalr_out_rs1", out_rs1, 32'h203);

        // Flush with an accept-eligible input: nothing accepted
        flush = 1'b1;
        feed(1'b1, 32'h500, I_JAL_0_8);
        @(negedge clk);
        check("flush_accept_ready", in_ready, 0);
        check("flush_accept_pc_sel", pc_sel, 0);
        tick();
        flush = 1'b0;
        check("flush_accept_valid", out_valid, 0);
        @(negedge clk);
        check("retry_pc_sel", pc_sel, 1);
        check("retry_pc_bj", pc_bj, 32'h508);
        tick();
        feed(1'b0, 32'h0, 32'h0);
        check("retry_out_pc", out_pc, 32'h500);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
